// File: rtl/ptp_egress_ts_tracker.sv
// Pairs MAC TX egress timestamps with queued request fingerprints and flags
// match, mismatch, timeout, overflow and unexpected-return events.
module ptp_egress_ts_tracker #(
  parameter int unsigned FP_WIDTH       = 4,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TS_WIDTH       = 96
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    req_valid,
  input  logic [FP_WIDTH-1:0]     req_fingerprint,
  input  logic                    ts_valid,
  input  logic [FP_WIDTH-1:0]     ts_fingerprint,
  input  logic [TS_WIDTH-1:0]     ts_data,
  output logic [$clog2(DEPTH):0]  outstanding,
  output logic                    match_pulse,
  output logic                    mismatch_pulse,
  output logic                    timeout_pulse,
  output logic [TS_WIDTH-1:0]     last_ts,
  output logic [FP_WIDTH-1:0]     last_fp,
  output logic [15:0]             req_count,
  output logic [15:0]             match_count,
  output logic [15:0]             mismatch_count,
  output logic [15:0]             timeout_count,
  output logic                    overflow,
  output logic                    unexpected
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned NW = 16;

  typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [FP_WIDTH-1:0] fifo_mem [DEPTH];

  logic [CW-1:0]       outstanding_d;
  logic                match_d, mismatch_d, timeout_d;
  logic [TS_WIDTH-1:0] last_ts_d;
  logic [FP_WIDTH-1:0] last_fp_d;
  logic [NW-1:0]       req_count_d, match_count_d, mismatch_count_d, timeout_count_d;
  logic                overflow_d, unexpected_d;

  logic                armed, ret, tmo, pop, full, push_ok, hit;
  logic [FP_WIDTH-1:0] head_fp;

  function automatic logic [NW-1:0] sat_inc(input logic [NW-1:0] v);
    return (v == {NW{1'b1}}) ? v : v + NW'(1);
  endfunction

  // A return beats a timeout; a pop in the same cycle frees a slot for a push.
  assign armed   = (state_q == ARMED);
  assign head_fp = fifo_mem[rd_ptr_q];
  assign ret     = armed && ts_valid;
  assign tmo     = armed && !ts_valid && (timer_q == TW'(TIMEOUT_CYCLES - 1));
  assign pop     = ret || tmo;
  assign full    = (outstanding == CW'(DEPTH));
  assign push_ok = req_valid && (!full || pop);
  assign hit     = ret && (ts_fingerprint == head_fp);

  always_comb begin
    state_d          = state_q;
    timer_d          = timer_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    outstanding_d    = outstanding;
    match_d          = 1'b0;
    mismatch_d       = 1'b0;
    timeout_d        = 1'b0;
    last_ts_d        = last_ts;
    last_fp_d        = last_fp;
    req_count_d      = req_count;
    match_count_d    = match_count;
    mismatch_count_d = mismatch_count;
    timeout_count_d  = timeout_count;
    overflow_d       = overflow;
    unexpected_d     = unexpected;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (push_ok) state_d = ARMED;
      end
      ARMED: begin
        timer_d = pop ? '0 : timer_q + TW'(1);
        if (pop && (outstanding == CW'(1)) && !push_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop)      outstanding_d = outstanding + CW'(1);
    else if (pop && !push_ok) outstanding_d = outstanding - CW'(1);

    if (hit) begin
      match_d       = 1'b1;
      match_count_d = sat_inc(match_count);
      last_ts_d     = ts_data;
      last_fp_d     = ts_fingerprint;
    end else if (ret) begin
      mismatch_d       = 1'b1;
      mismatch_count_d = sat_inc(mismatch_count);
    end else if (tmo) begin
      timeout_d       = 1'b1;
      timeout_count_d = sat_inc(timeout_count);
    end

    if (req_valid) req_count_d = sat_inc(req_count);
    if (req_valid && !push_ok) overflow_d = 1'b1;
    if (ts_valid && !armed) unexpected_d = 1'b1;

    // Clear wins over any event in the same cycle.
    if (clear) begin
      req_count_d      = '0;
      match_count_d    = '0;
      mismatch_count_d = '0;
      timeout_count_d  = '0;
      overflow_d       = 1'b0;
      unexpected_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      outstanding    <= '0;
      match_pulse    <= 1'b0;
      mismatch_pulse <= 1'b0;
      timeout_pulse  <= 1'b0;
      last_ts        <= '0;
      last_fp        <= '0;
      req_count      <= '0;
      match_count    <= '0;
      mismatch_count <= '0;
      timeout_count  <= '0;
      overflow       <= 1'b0;
      unexpected     <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      outstanding    <= outstanding_d;
      match_pulse    <= match_d;
      mismatch_pulse <= mismatch_d;
      timeout_pulse  <= timeout_d;
      last_ts        <= last_ts_d;
      last_fp        <= last_fp_d;
      req_count      <= req_count_d;
      match_count    <= match_count_d;
      mismatch_count <= mismatch_count_d;
      timeout_count  <= timeout_count_d;
      overflow       <= overflow_d;
      unexpected     <= unexpected_d;
    end
  end

  // Fingerprint storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= req_fingerprint;
  end

endmodule

// File: tb/tb_ptp_egress_ts_tracker.sv
// Randomized scoreboard bench for ptp_egress_ts_tracker with a queue-based
// reference model and directed scenarios for the corner cases.
module tb_ptp_egress_ts_tracker;

  localparam int TO  = 16;
  localparam int DEP = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear, req_valid, ts_valid;
  logic [3:0]  req_fingerprint, ts_fingerprint;
  logic [95:0] ts_data;
  logic [3:0]  outstanding;
  logic        match_pulse, mismatch_pulse, timeout_pulse;
  logic [95:0] last_ts;
  logic [3:0]  last_fp;
  logic [15:0] req_count, match_count, mismatch_count, timeout_count;
  logic        overflow, unexpected;

  ptp_egress_ts_tracker #(
    .FP_WIDTH(4), .DEPTH(DEP), .TIMEOUT_CYCLES(TO), .TS_WIDTH(96)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .req_valid(req_valid), .req_fingerprint(req_fingerprint),
    .ts_valid(ts_valid), .ts_fingerprint(ts_fingerprint), .ts_data(ts_data),
    .outstanding(outstanding), .match_pulse(match_pulse),
    .mismatch_pulse(mismatch_pulse), .timeout_pulse(timeout_pulse),
    .last_ts(last_ts), .last_fp(last_fp), .req_count(req_count),
    .match_count(match_count), .mismatch_count(mismatch_count),
    .timeout_count(timeout_count), .overflow(overflow), .unexpected(unexpected)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 match, 1 mismatch, 2 timeout
    logic [3:0]  fp;
    logic [95:0] ts;
    int          cyc;
  } ev_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_tmo_cyc = -1;
  ev_t  expq[$];

  // Reference model state
  logic [3:0]  mq[$];
  int          age;
  logic [15:0] m_req, m_match, m_mis, m_tmo;
  bit          m_ovf, m_unx;
  logic [3:0]  m_lfp;
  logic [95:0] m_lts;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic model_reset();
    mq.delete();
    expq.delete();
    age = 0;
    m_req = '0; m_match = '0; m_mis = '0; m_tmo = '0;
    m_ovf = 0; m_unx = 0; m_lfp = '0; m_lts = '0;
  endtask

  task automatic model_step(input bit rv, input logic [3:0] rfp, input bit tv,
                            input logic [3:0] tfp, input logic [95:0] td, input bit clr);
    bit  armed, ret, tmo, pop, accept;
    ev_t e;
    armed = (mq.size() != 0);
    ret   = armed && tv;
    tmo   = armed && !tv && (age == TO - 1);
    pop   = ret || tmo;
    e.cyc = cyc + 1; e.fp = tfp; e.ts = td; e.kind = 0;
    if (ret) begin
      if (mq[0] == tfp) begin
        e.kind = 0; m_lfp = tfp; m_lts = td; m_match = sat(m_match);
      end else begin
        e.kind = 1; m_mis = sat(m_mis);
      end
      expq.push_back(e);
    end else if (tmo) begin
      e.kind = 2; m_tmo = sat(m_tmo);
      expq.push_back(e);
    end
    if (tv && !armed) m_unx = 1;
    accept = rv && ((mq.size() < DEP) || pop);
    if (rv) begin
      m_req = sat(m_req);
      if (!accept) m_ovf = 1;
    end
    if (pop) void'(mq.pop_front());
    if (accept) mq.push_back(rfp);
    if (armed && !pop) age++;
    else age = 0;
    if (clr) begin
      m_req = '0; m_match = '0; m_mis = '0; m_tmo = '0; m_ovf = 0; m_unx = 0;
    end
  endtask

  task automatic check_state();
    chk("outstanding", outstanding, mq.size());
    chk("req_count", req_count, m_req);
    chk("match_count", match_count, m_match);
    chk("mismatch_count", mismatch_count, m_mis);
    chk("timeout_count", timeout_count, m_tmo);
    chk("overflow", overflow, m_ovf);
    chk("unexpected", unexpected, m_unx);
    chk("last_fp", last_fp, m_lfp);
    chk("last_ts", last_ts, m_lts);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_outstanding"}, outstanding, 0);
    chk({tag, "_pulses"}, {match_pulse, mismatch_pulse, timeout_pulse}, 0);
    chk({tag, "_counts"}, {req_count, match_count, mismatch_count, timeout_count}, 0);
    chk({tag, "_flags"}, {overflow, unexpected}, 0);
    chk({tag, "_last"}, {last_fp, last_ts}, 0);
  endtask

  // One clock of stimulus: model predicts, DUT samples, state compared after edge.
  task automatic tick(input bit rv, input logic [3:0] rfp, input bit tv,
                      input logic [3:0] tfp, input logic [95:0] td, input bit clr);
    req_valid = rv; req_fingerprint = rfp;
    ts_valid = tv; ts_fingerprint = tfp; ts_data = td; clear = clr;
    model_step(rv, rfp, tv, tfp, td, clr);
    @(posedge clk);
    #1;
    req_valid = 0; ts_valid = 0; clear = 0;
    check_state();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 4'h0, 0, 4'h0, '0, 0);
  endtask

  task automatic do_reset();
    #2;
    reset = 1;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pulse.
  always @(negedge clk) begin
    ev_t e;
    int  n, kind;
    if (!reset) begin
      if (timeout_pulse) last_tmo_cyc = cyc;
      while (expq.size() > 0 && expq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL pulse_missing: kind %0d due at cyc %0d, not observed by cyc %0d",
                 expq[0].kind, expq[0].cyc, cyc);
        void'(expq.pop_front());
      end
      n = int'(match_pulse) + int'(mismatch_pulse) + int'(timeout_pulse);
      if (n > 0) begin
        kind = match_pulse ? 0 : (mismatch_pulse ? 1 : 2);
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL pulse_spurious: got kind %0d at cyc %0d, expected none", kind, cyc);
        end else begin
          e = expq.pop_front();
          chk("pulse_onehot", n, 1);
          chk("pulse_kind", kind, e.kind);
          chk("pulse_cycle", cyc, e.cyc);
          if (e.kind == 0) begin
            chk("pulse_last_fp", last_fp, e.fp);
            chk("pulse_last_ts", last_ts, e.ts);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int pr_t[6] = '{40, 70, 20, 50, 90, 10};
    int pt_t[6] = '{40, 20, 5, 50, 10, 60};
    int pe;
    logic [3:0] tfp;
    reset = 1; clear = 0; req_valid = 0; ts_valid = 0;
    req_fingerprint = '0; ts_fingerprint = '0; ts_data = '0;
    model_reset();
    #12;
    check_zero("por");
    #10;
    reset = 0;

    // In-order matches
    tick(1, 4'd0, 0, 4'd0, '0, 0);
    tick(1, 4'd1, 0, 4'd0, '0, 0);
    tick(1, 4'd2, 0, 4'd0, '0, 0);
    tick(0, 4'd0, 1, 4'd0, 96'h12, 0);
    tick(0, 4'd0, 1, 4'd1, 96'h13, 0);
    tick(0, 4'd0, 1, 4'd2, 96'h14, 0);
    chk("t1_match_count", match_count, 3);
    chk("t1_last_fp", last_fp, 2);
    chk("t1_last_ts", last_ts, 96'h14);
    chk("t1_outstanding", outstanding, 0);

    // Mismatch leaves last_* alone
    tick(1, 4'd5, 0, 4'd0, '0, 0);
    tick(0, 4'd0, 1, 4'd3, 96'h99, 0);
    chk("t2_mismatch_count", mismatch_count, 1);
    chk("t2_last_fp", last_fp, 2);
    chk("t2_outstanding", outstanding, 0);

    // Timeout latency, then return on the final timer cycle
    tick(1, 4'd4, 0, 4'd0, '0, 0);
    pe = cyc;
    idle(17);
    chk("t3_timeout_cycle", last_tmo_cyc, pe + 16);
    chk("t3_timeout_count", timeout_count, 1);
    tick(1, 4'd4, 0, 4'd0, '0, 0);
    idle(15);
    tick(0, 4'd0, 1, 4'd4, 96'hABC, 0);
    idle(1);
    chk("t3b_timeout_count", timeout_count, 1);
    chk("t3b_match_count", match_count, 4);
    chk("t3b_last_ts", last_ts, 96'hABC);

    // Overflow, then push+pop while full
    tick(0, 4'd0, 0, 4'd0, '0, 1);
    for (int i = 0; i < 9; i++) tick(1, 4'(i), 0, 4'd0, '0, 0);
    chk("t4_overflow", overflow, 1);
    chk("t4_req_count", req_count, 9);
    chk("t4_outstanding", outstanding, 8);
    tick(0, 4'd0, 0, 4'd0, '0, 1);
    tick(1, 4'd9, 1, 4'd0, 96'h55, 0);
    chk("t4b_overflow", overflow, 0);
    chk("t4b_outstanding", outstanding, 8);
    for (int i = 0; i < 8; i++) tick(0, 4'd0, 1, mq[0], 96'(i + 100), 0);

    // Unexpected return, then clear
    tick(0, 4'd0, 0, 4'd0, '0, 1);
    tick(0, 4'd0, 1, 4'd7, 96'h1, 0);
    chk("t5_unexpected", unexpected, 1);
    chk("t5_counts", {req_count, match_count, mismatch_count, timeout_count}, 0);
    tick(0, 4'd0, 0, 4'd0, '0, 1);
    chk("t5_cleared", unexpected, 0);

    // Push into empty queue alongside a return
    tick(1, 4'd6, 1, 4'd6, 96'h2, 0);
    chk("t5b_unexpected", unexpected, 1);
    chk("t5b_outstanding", outstanding, 1);
    tick(0, 4'd0, 1, 4'd6, 96'h3, 0);

    // Reset mid-operation
    tick(1, 4'd1, 0, 4'd0, '0, 0);
    tick(1, 4'd2, 0, 4'd0, '0, 0);
    tick(1, 4'd3, 0, 4'd0, '0, 0);
    idle(5);
    do_reset();
    tick(0, 4'd0, 1, 4'd1, 96'h7, 0);
    chk("t6_unexpected", unexpected, 1);
    chk("t6_outstanding", outstanding, 0);

    // Randomized traffic at varying request/return rates
    for (int blk = 0; blk < 6; blk++) begin
      for (int i = 0; i < 250; i++) begin
        if (mq.size() > 0 && $urandom_range(3) != 0) tfp = mq[0];
        else tfp = 4'($urandom);
        tick($urandom_range(99) < pr_t[blk], 4'($urandom),
             $urandom_range(99) < pt_t[blk], tfp,
             {$urandom, $urandom, $urandom}, $urandom_range(199) == 0);
      end
    end

    idle(DEP * TO + 4);
    chk("scoreboard_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
